// File: rtl/mult_wb_merge_pkg.sv
// Types shared between the multiplier top and its writeback merge unit:
// the result bus record and the register-file write source tag.
package mult_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] rd;
    logic              ready;
  } mult_bus;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_FIFO,
    WB_BYPASS
  } wb_src_e;

endpackage

// File: rtl/mult_wb_merge_if.sv
// Signal bundle between the pipeline and the multiply writeback merge unit.
// The multiplier result is a one-cycle strobe (i_mult_ready): there is no ready back-pressure,
// so the consumer must accept it in the cycle it is presented (write, buffer, or flag overflow).
import mult_wb_pkg::*;

interface mult_wb_merge_if #(
  parameter int DEPTH = 4
);
  logic                  i_mult_ready;
  logic [ADDR_W-1:0]     i_mult_rd;
  logic [DATA_W-1:0]     i_mult_result;
  logic                  i_alu_wb_en;
  logic [ADDR_W-1:0]     i_alu_wb_rd;
  logic [DATA_W-1:0]     i_alu_wb_data;
  logic                  i_issue_mult;
  logic [ADDR_W-1:0]     i_issue_rd;
  logic [ADDR_W-1:0]     i_src_rs;
  logic [ADDR_W-1:0]     i_src_rt;
  logic [ADDR_W-1:0]     i_dst_rd;
  logic                  o_rf_we;
  logic [ADDR_W-1:0]     o_rf_waddr;
  logic [DATA_W-1:0]     o_rf_wdata;
  logic                  o_stall;
  logic                  o_mult_block;
  logic [$clog2(DEPTH):0]   o_fifo_count;
  logic                  o_overflow;
  wb_src_e               dbg_wb_src;
  logic [$clog2(DEPTH)+1:0] dbg_inflight;

  modport slave (
    input  i_mult_ready, i_mult_rd, i_mult_result,
    input  i_alu_wb_en, i_alu_wb_rd, i_alu_wb_data,
    input  i_issue_mult, i_issue_rd,
    input  i_src_rs, i_src_rt, i_dst_rd,
    output o_rf_we, o_rf_waddr, o_rf_wdata,
    output o_stall, o_mult_block, o_fifo_count, o_overflow,
    output dbg_wb_src, dbg_inflight
  );

  modport master (
    output i_mult_ready, i_mult_rd, i_mult_result,
    output i_alu_wb_en, i_alu_wb_rd, i_alu_wb_data,
    output i_issue_mult, i_issue_rd,
    output i_src_rs, i_src_rt, i_dst_rd,
    input  o_rf_we, o_rf_waddr, o_rf_wdata,
    input  o_stall, o_mult_block, o_fifo_count, o_overflow,
    input  dbg_wb_src, dbg_inflight
  );

endinterface

// File: rtl/mult_wb_merge_fifo.sv
// Synchronous FIFO of multiplier results. A push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle; otherwise it is dropped.
import mult_wb_pkg::*;

module mult_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  mult_bus                din,
  output mult_bus                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mult_bus         mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/mult_wb_merge.sv
// Merges multiplier results with ALU/load writeback onto the single RF write port,
// tracks pending multiply destinations and raises decode stall / issue throttle.
import mult_wb_pkg::*;

module mult_wb_merge #(
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mult_wb_merge_if.slave  bus
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int IW   = $clog2(DEPTH) + 2;
  localparam int SW   = IW + 1;
  localparam int NREG = 1 << ADDR_W;

  mult_bus           in_bus;
  mult_bus           fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push;
  logic              fifo_pop;
  wb_src_e           sel;
  logic [IW-1:0]     inflight;
  logic [SW-1:0]     occupancy;
  logic              mult_block;
  logic [NREG-1:0]   pend;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_rd;
  logic              overflow;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign in_bus.result = bus.i_mult_result;
  assign in_bus.rd     = bus.i_mult_rd;
  assign in_bus.ready  = bus.i_mult_ready;

  mult_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_bus),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Port priority: ALU, then buffered results (keeps per-rd order), then bypass.
  always_comb begin
    sel = WB_NONE;
    if (bus.i_alu_wb_en)                   sel = WB_ALU;
    else if (!fifo_empty && fifo_head.ready) sel = WB_FIFO;
    else if (bus.i_mult_ready)             sel = WB_BYPASS;
  end

  assign fifo_push = bus.i_mult_ready && (sel != WB_BYPASS);
  assign fifo_pop  = (sel == WB_FIFO);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (sel != WB_NONE);
      case (sel)
        WB_ALU: begin
          rf_waddr <= bus.i_alu_wb_rd;
          rf_wdata <= bus.i_alu_wb_data;
        end
        WB_FIFO: begin
          rf_waddr <= fifo_head.rd;
          rf_wdata <= fifo_head.result;
        end
        WB_BYPASS: begin
          rf_waddr <= bus.i_mult_rd;
          rf_wdata <= bus.i_mult_result;
        end
        default: begin
          rf_waddr <= rf_waddr;
          rf_wdata <= rf_wdata;
        end
      endcase
    end
  end

  // Drop-on-full is sticky so software can see a lost result after the fact.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                      overflow <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop)   overflow <= 1'b1;
  end

  // Floor at zero so a stray ready without an issue cannot wrap the counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight <= '0;
    end else if (bus.i_issue_mult && !bus.i_mult_ready) begin
      inflight <= inflight + IW'(1);
    end else if (bus.i_mult_ready && !bus.i_issue_mult && (inflight != '0)) begin
      inflight <= inflight - IW'(1);
    end
  end

  assign occupancy  = SW'(inflight) + SW'(fifo_count);
  assign mult_block = (occupancy >= SW'(DEPTH));

  assign clr_en = (sel == WB_FIFO) || (sel == WB_BYPASS);
  assign clr_rd = (sel == WB_FIFO) ? fifo_head.rd : bus.i_mult_rd;

  // Set is written after clear so a same-cycle set on the same bit wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend <= '0;
    end else begin
      if (clr_en) pend[clr_rd] <= 1'b0;
      if (bus.i_issue_mult && (bus.i_issue_rd != '0)) pend[bus.i_issue_rd] <= 1'b1;
    end
  end

  always_comb begin
    bus.o_stall = 1'b0;
    if ((bus.i_src_rs != '0) && pend[bus.i_src_rs]) bus.o_stall = 1'b1;
    if ((bus.i_src_rt != '0) && pend[bus.i_src_rt]) bus.o_stall = 1'b1;
    if ((bus.i_dst_rd != '0) && pend[bus.i_dst_rd]) bus.o_stall = 1'b1;
    if (bus.i_issue_mult && mult_block)              bus.o_stall = 1'b1;
  end

  assign bus.o_rf_we      = rf_we;
  assign bus.o_rf_waddr   = rf_waddr;
  assign bus.o_rf_wdata   = rf_wdata;
  assign bus.o_mult_block = mult_block;
  assign bus.o_fifo_count = fifo_count;
  assign bus.o_overflow   = overflow;
  assign bus.dbg_wb_src   = sel;
  assign bus.dbg_inflight = inflight;

endmodule

// File: tb/tb_mult_wb_merge.sv
// Directed bench for mult_wb_merge: port priority, FIFO ordering/overflow,
// inflight accounting, scoreboard stall and mid-operation reset.
import mult_wb_pkg::*;

module tb_mult_wb_merge;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  mult_wb_merge_if bus ();

  mult_wb_merge dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_checks++;
    if (obs !== exp_val) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_mult_ready  = 1'b0;
    bus.i_mult_rd     = '0;
    bus.i_mult_result = '0;
    bus.i_alu_wb_en   = 1'b0;
    bus.i_alu_wb_rd   = '0;
    bus.i_alu_wb_data = '0;
    bus.i_issue_mult  = 1'b0;
    bus.i_issue_rd    = '0;
    bus.i_src_rs      = '0;
    bus.i_src_rt      = '0;
    bus.i_dst_rd      = '0;
  endtask

  task automatic issue(input int rd);
    bus.i_issue_mult = 1'b1;
    bus.i_issue_rd   = ADDR_W'(rd);
    tick();
    bus.i_issue_mult = 1'b0;
  endtask

  task automatic deliver(input int rd, input logic [31:0] res);
    bus.i_mult_ready  = 1'b1;
    bus.i_mult_rd     = ADDR_W'(rd);
    bus.i_mult_result = res;
    tick();
    bus.i_mult_ready  = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [31:0] packed_exp);
    check({tag, "_we"},    32'(bus.o_rf_we), 32'd1);
    check({tag, "_waddr"}, 32'(bus.o_rf_waddr), {24'd0, packed_exp[31:24]});
    check({tag, "_wdata"}, bus.o_rf_wdata, {8'd0, packed_exp[23:0]});
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("rst_we",       32'(bus.o_rf_we), 32'd0);
    check("rst_waddr",    32'(bus.o_rf_waddr), 32'd0);
    check("rst_wdata",    bus.o_rf_wdata, 32'd0);
    check("rst_count",    32'(bus.o_fifo_count), 32'd0);
    check("rst_overflow", 32'(bus.o_overflow), 32'd0);
    check("rst_block",    32'(bus.o_mult_block), 32'd0);
    rst = 1'b0;

    // Lone multiply takes the bypass path.
    issue(8);
    bus.i_src_rs = ADDR_W'(8);
    #1;
    check("lone_stall_pending", 32'(bus.o_stall), 32'd1);
    check("lone_inflight",      32'(bus.dbg_inflight), 32'd1);
    deliver(8, 32'h0000_0015);
    check_write("lone", {8'd8, 24'h15});
    check("lone_count",    32'(bus.o_fifo_count), 32'd0);
    check("lone_stall_clr", 32'(bus.o_stall), 32'd0);
    check("lone_inflight0", 32'(bus.dbg_inflight), 32'd0);

    // ALU and multiplier collide: ALU first, mult buffered then written.
    idle();
    issue(9);
    bus.i_alu_wb_en   = 1'b1;
    bus.i_alu_wb_rd   = ADDR_W'(3);
    bus.i_alu_wb_data = 32'h00A1_0005;
    deliver(9, 32'h0000_0099);
    idle();
    bus.i_src_rs = ADDR_W'(9);
    #1;
    check_write("conf_alu", {8'd3, 24'hA1_0005});
    check("conf_count1", 32'(bus.o_fifo_count), 32'd1);
    check("conf_stall",  32'(bus.o_stall), 32'd1);
    tick();
    check_write("conf_fifo", {8'd9, 24'h99});
    check("conf_count0", 32'(bus.o_fifo_count), 32'd0);
    check("conf_stall0", 32'(bus.o_stall), 32'd0);
    tick();
    check("conf_idle_we", 32'(bus.o_rf_we), 32'd0);

    // RAW/WAW stall against pending rd=5; r0 never stalls.
    idle();
    issue(5);
    issue(0);
    bus.i_src_rs = ADDR_W'(5);
    #1;
    check("raw_rs5", 32'(bus.o_stall), 32'd1);
    bus.i_src_rs = '0;
    #1;
    check("raw_r0", 32'(bus.o_stall), 32'd0);
    bus.i_dst_rd = ADDR_W'(5);
    #1;
    check("waw_rd5", 32'(bus.o_stall), 32'd1);
    bus.i_dst_rd = '0;
    bus.i_src_rt = ADDR_W'(5);
    #1;
    check("raw_rt5", 32'(bus.o_stall), 32'd1);
    check("raw_inflight2", 32'(bus.dbg_inflight), 32'd2);
    deliver(5, 32'h0000_0055);
    check("raw_cleared", 32'(bus.o_stall), 32'd0);
    check_write("raw_wr5", {8'd5, 24'h55});
    deliver(0, 32'h0000_1234);
    check_write("raw_wr0", {8'd0, 24'h1234});
    check("raw_inflight0", 32'(bus.dbg_inflight), 32'd0);

    // Fill the FIFO behind a busy ALU, overflow, then drain in push order.
    idle();
    bus.i_alu_wb_en   = 1'b1;
    bus.i_alu_wb_rd   = ADDR_W'(1);
    bus.i_alu_wb_data = 32'h0000_0011;
    for (int i = 0; i < 6; i++) issue(10 + i);
    check("fill_inflight6", 32'(bus.dbg_inflight), 32'd6);
    check("fill_block_inflight", 32'(bus.o_mult_block), 32'd1);
    check_write("fill_alu", {8'd1, 24'h11});
    bus.i_issue_mult = 1'b1;
    bus.i_issue_rd   = ADDR_W'(16);
    #1;
    check("fill_issue_stall", 32'(bus.o_stall), 32'd1);
    bus.i_issue_mult = 1'b0;
    for (int i = 0; i < 4; i++) begin
      deliver(10 + i, 32'h0000_00A0 + 32'(i));
      exp_q.push_back({8'(10 + i), 24'h0000A0 + 24'(i)});
      check($sformatf("fill_count%0d", i + 1), 32'(bus.o_fifo_count), 32'(i + 1));
    end
    check("fill_block_full", 32'(bus.o_mult_block), 32'd1);
    check("fill_no_ovf", 32'(bus.o_overflow), 32'd0);
    deliver(14, 32'h0000_00A4);
    check("ovf_set", 32'(bus.o_overflow), 32'd1);
    check("ovf_count", 32'(bus.o_fifo_count), 32'd4);
    check("ovf_inflight", 32'(bus.dbg_inflight), 32'd1);
    bus.i_alu_wb_en = 1'b0;
    tick();
    exp_v = exp_q.pop_front();
    check_write("drain0", exp_v);
    check("drain_count3", 32'(bus.o_fifo_count), 32'd3);
    tick();
    exp_v = exp_q.pop_front();
    check_write("drain1", exp_v);
    check("drain_count2", 32'(bus.o_fifo_count), 32'd2);
    exp_q.push_back({8'd15, 24'h0000B5});
    deliver(15, 32'h0000_00B5);
    exp_v = exp_q.pop_front();
    check_write("drain2_pushpop", exp_v);
    check("pushpop_count2", 32'(bus.o_fifo_count), 32'd2);
    tick();
    exp_v = exp_q.pop_front();
    check_write("drain3", exp_v);
    check("drain_count1", 32'(bus.o_fifo_count), 32'd1);
    tick();
    exp_v = exp_q.pop_front();
    check_write("drain4", exp_v);
    check("drain_count0", 32'(bus.o_fifo_count), 32'd0);
    check("ovf_sticky", 32'(bus.o_overflow), 32'd1);
    check("drain_inflight0", 32'(bus.dbg_inflight), 32'd0);
    check("drain_block0", 32'(bus.o_mult_block), 32'd0);

    // Issue and ready in the same cycle hold the inflight count.
    idle();
    issue(20);
    check("sim_inflight1", 32'(bus.dbg_inflight), 32'd1);
    bus.i_issue_mult = 1'b1;
    bus.i_issue_rd   = ADDR_W'(21);
    deliver(20, 32'h0000_0020);
    bus.i_issue_mult = 1'b0;
    check("sim_inflight_hold", 32'(bus.dbg_inflight), 32'd1);
    check_write("sim_wr20", {8'd20, 24'h20});
    deliver(21, 32'h0000_0021);
    check("sim_inflight0", 32'(bus.dbg_inflight), 32'd0);

    // Reset in the middle of buffered traffic.
    idle();
    bus.i_alu_wb_en   = 1'b1;
    bus.i_alu_wb_rd   = ADDR_W'(2);
    bus.i_alu_wb_data = 32'h0000_0022;
    issue(7);
    issue(22);
    issue(23);
    deliver(7, 32'h0000_0007);
    deliver(22, 32'h0000_0016);
    deliver(23, 32'h0000_0017);
    bus.i_src_rs = ADDR_W'(7);
    #1;
    check("mid_count3", 32'(bus.o_fifo_count), 32'd3);
    check("mid_stall",  32'(bus.o_stall), 32'd1);
    rst = 1'b1;
    bus.i_alu_wb_en = 1'b0;
    tick();
    check("mrst_count",    32'(bus.o_fifo_count), 32'd0);
    check("mrst_stall",    32'(bus.o_stall), 32'd0);
    check("mrst_we",       32'(bus.o_rf_we), 32'd0);
    check("mrst_overflow", 32'(bus.o_overflow), 32'd0);
    check("mrst_inflight", 32'(bus.dbg_inflight), 32'd0);
    rst = 1'b0;
    idle();
    tick();
    check("post_rst_we", 32'(bus.o_rf_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
